// File: rtl/loader_sdram_sink.sv
// Loader write sink: accepts byte writes from the image loader, packs even/odd
// byte pairs into 16-bit SDRAM writes with byte enables, and acks each byte once.
module loader_sdram_sink #(
  parameter int          ADR_W  = 19,
  parameter int          RAM_AW = 24,
  parameter int unsigned BASE   = 0,
  parameter int unsigned LIMIT  = 2**19
) (
  input  logic              clk21m,
  input  logic              rstn,
  input  logic              LOADER_OE,
  input  logic              LOADER_WR,
  input  logic [ADR_W-1:0]  LOADER_ADR,
  input  logic [7:0]        LOADER_WDAT,
  output logic              LOADER_ACK,
  output logic              ram_req,
  input  logic              ram_ack,
  output logic [RAM_AW-1:0] ram_adr,
  output logic [15:0]       ram_wdat,
  output logic [1:0]        ram_be,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  // Handshake: LOADER_WR is a level that may trail LOADER_ACK, so a byte is taken
  // only after WR has been seen low (armed). ram_req is a level held with stable
  // adr/wdat/be until a ram_ack pulse; ram_ack is ignored while ram_req is low.
  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_PROC, S_WRITE} state_t;

  state_t             state_q, state_d;
  state_t             ret_q, ret_d;
  logic               armed_q, armed_d;
  logic               pend_v_q, pend_v_d;
  logic [ADR_W-2:0]   pend_adr_q, pend_adr_d;
  logic [7:0]         pend_dat_q, pend_dat_d;
  logic [ADR_W-1:0]   cap_adr_q, cap_adr_d;
  logic [7:0]         cap_dat_q, cap_dat_d;
  logic               ack_q, ack_d;
  logic               req_q, req_d;
  logic [RAM_AW-1:0]  adr_q, adr_d;
  logic [15:0]        wdat_q, wdat_d;
  logic [1:0]         be_q, be_d;
  logic [7:0]         drop_q, drop_d;

  logic accept;
  logic in_range;
  logic ram_done;
  logic pend_match;

  function automatic logic [RAM_AW-1:0] word_addr(input logic [ADR_W-2:0] w);
    return RAM_AW'(BASE) + RAM_AW'(w);
  endfunction

  assign accept     = LOADER_WR && armed_q && LOADER_OE && (state_q == S_IDLE);
  assign in_range   = 32'(LOADER_ADR) < LIMIT;
  assign ram_done   = ram_ack && req_q;
  assign pend_match = pend_v_q && (pend_adr_q == cap_adr_q[ADR_W-1:1]);

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    armed_d    = armed_q;
    pend_v_d   = pend_v_q;
    pend_adr_d = pend_adr_q;
    pend_dat_d = pend_dat_q;
    cap_adr_d  = cap_adr_q;
    cap_dat_d  = cap_dat_q;
    ack_d      = 1'b0;
    req_d      = req_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    be_d       = be_q;
    drop_d     = drop_q;

    if (!LOADER_WR) armed_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          armed_d   = 1'b0;
          cap_adr_d = LOADER_ADR;
          cap_dat_d = LOADER_WDAT;
          if (!in_range) begin
            // Out-of-window byte: ack it so the loader keeps going, keep any pending byte.
            ack_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          end else if (pend_v_q &&
                       (!LOADER_ADR[0] || (LOADER_ADR[ADR_W-1:1] != pend_adr_q))) begin
            state_d = S_FLUSH;
            ret_d   = S_PROC;
            req_d   = 1'b1;
            adr_d   = word_addr(pend_adr_q);
            wdat_d  = {8'h00, pend_dat_q};
            be_d    = 2'b01;
          end else begin
            state_d = S_PROC;
          end
        end else if (!LOADER_OE && pend_v_q) begin
          state_d = S_FLUSH;
          ret_d   = S_IDLE;
          req_d   = 1'b1;
          adr_d   = word_addr(pend_adr_q);
          wdat_d  = {8'h00, pend_dat_q};
          be_d    = 2'b01;
        end
      end
      S_FLUSH: begin
        if (ram_done) begin
          req_d    = 1'b0;
          pend_v_d = 1'b0;
          state_d  = ret_q;
        end
      end
      S_PROC: begin
        if (!cap_adr_q[0]) begin
          pend_adr_d = cap_adr_q[ADR_W-1:1];
          pend_dat_d = cap_dat_q;
          pend_v_d   = 1'b1;
          ack_d      = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_WRITE;
          req_d   = 1'b1;
          adr_d   = word_addr(cap_adr_q[ADR_W-1:1]);
          if (pend_match) begin
            wdat_d   = {cap_dat_q, pend_dat_q};
            be_d     = 2'b11;
            pend_v_d = 1'b0;
          end else begin
            wdat_d = {cap_dat_q, 8'h00};
            be_d   = 2'b10;
          end
        end
      end
      S_WRITE: begin
        if (ram_done) begin
          req_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk21m or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      armed_q    <= 1'b1;
      pend_v_q   <= 1'b0;
      pend_adr_q <= '0;
      pend_dat_q <= '0;
      cap_adr_q  <= '0;
      cap_dat_q  <= '0;
      ack_q      <= 1'b0;
      req_q      <= 1'b0;
      adr_q      <= '0;
      wdat_q     <= '0;
      be_q       <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      armed_q    <= armed_d;
      pend_v_q   <= pend_v_d;
      pend_adr_q <= pend_adr_d;
      pend_dat_q <= pend_dat_d;
      cap_adr_q  <= cap_adr_d;
      cap_dat_q  <= cap_dat_d;
      ack_q      <= ack_d;
      req_q      <= req_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      be_q       <= be_d;
      drop_q     <= drop_d;
    end
  end

  assign LOADER_ACK = ack_q;
  assign ram_req    = req_q;
  assign ram_adr    = adr_q;
  assign ram_wdat   = wdat_q;
  assign ram_be     = be_q;
  assign drop_cnt   = drop_q;
  assign busy       = (state_q != S_IDLE) || pend_v_q;

endmodule

// File: tb/tb_loader_sdram_sink.sv
// Bench for loader_sdram_sink: randomized byte writes checked against a byte-pairing
// reference model, with an SDRAM responder scoreboarding every write request.
module tb_loader_sdram_sink;

  localparam int          ADR_W  = 19;
  localparam int          RAM_AW = 24;
  localparam int unsigned BASE   = 32'h100;
  localparam int unsigned LIMIT  = 32'h100;
  localparam int          W      = RAM_AW + 18;

  logic              clk21m;
  logic              rstn;
  logic              LOADER_OE;
  logic              LOADER_WR;
  logic [ADR_W-1:0]  LOADER_ADR;
  logic [7:0]        LOADER_WDAT;
  logic              LOADER_ACK;
  logic              ram_req;
  logic              ram_ack;
  logic [RAM_AW-1:0] ram_adr;
  logic [15:0]       ram_wdat;
  logic [1:0]        ram_be;
  logic              busy;
  logic [7:0]        drop_cnt;

  loader_sdram_sink #(.ADR_W(ADR_W), .RAM_AW(RAM_AW), .BASE(BASE), .LIMIT(LIMIT)) dut (
    .clk21m(clk21m), .rstn(rstn), .LOADER_OE(LOADER_OE), .LOADER_WR(LOADER_WR),
    .LOADER_ADR(LOADER_ADR), .LOADER_WDAT(LOADER_WDAT), .LOADER_ACK(LOADER_ACK),
    .ram_req(ram_req), .ram_ack(ram_ack), .ram_adr(ram_adr), .ram_wdat(ram_wdat),
    .ram_be(ram_be), .busy(busy), .drop_cnt(drop_cnt)
  );

  // clock / reset
  initial clk21m = 1'b0;
  always #5 clk21m = ~clk21m;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt  = 0;
  int req_cnt  = 0;
  bit ack_prev = 0;
  bit resp_en  = 1;
  bit oe_drop  = 0;

  // scoreboard: expected {ram_adr, ram_wdat, ram_be} per SDRAM request
  logic [W-1:0] exp_q[$];

  // reference model state
  bit               m_pend_v = 0;
  logic [ADR_W-2:0] m_pend_w;
  logic [7:0]       m_pend_d;
  int               m_drop = 0;

  function automatic void model_emit(input logic [ADR_W-2:0] word, input logic [15:0] wd,
                                     input logic [1:0] be);
    logic [RAM_AW-1:0] a;
    a = RAM_AW'(BASE) + RAM_AW'(word);
    exp_q.push_back({a, wd, be});
  endfunction

  function automatic void model_write(input logic [ADR_W-1:0] adr, input logic [7:0] dat);
    logic [ADR_W-2:0] word;
    word = adr[ADR_W-1:1];
    if (32'(adr) >= LIMIT) begin
      if (m_drop < 255) m_drop++;
    end else if (!adr[0]) begin
      if (m_pend_v) model_emit(m_pend_w, {8'h00, m_pend_d}, 2'b01);
      m_pend_v = 1;
      m_pend_w = word;
      m_pend_d = dat;
    end else if (m_pend_v && m_pend_w == word) begin
      model_emit(word, {dat, m_pend_d}, 2'b11);
      m_pend_v = 0;
    end else begin
      if (m_pend_v) model_emit(m_pend_w, {8'h00, m_pend_d}, 2'b01);
      m_pend_v = 0;
      model_emit(word, {dat, 8'h00}, 2'b10);
    end
  endfunction

  function automatic void model_end_session();
    if (m_pend_v) model_emit(m_pend_w, {8'h00, m_pend_d}, 2'b01);
    m_pend_v = 0;
  endfunction

  // ACK monitor: counts pulses and checks they are single-cycle
  always @(negedge clk21m) begin
    if (rstn && LOADER_ACK) begin
      ack_cnt++;
      n_checks++;
      if (ack_prev) begin
        n_errors++;
        $display("FAIL ack_pulse: ACK high in two consecutive cycles, required single-cycle pulse");
      end
    end
    ack_prev = rstn && LOADER_ACK;
  end

  // SDRAM responder: scoreboards each new request, checks stability, acks after 0..3 cycles
  initial begin : responder
    logic [W-1:0] snap;
    logic [W-1:0] exp_v;
    int dly;
    bit in_req;
    in_req = 0;
    dly = 0;
    forever begin
      @(negedge clk21m);
      if (resp_en && rstn && ram_req) begin
        if (!in_req) begin
          in_req = 1;
          req_cnt++;
          snap = {ram_adr, ram_wdat, ram_be};
          dly = $urandom_range(0, 3);
          if (oe_drop) LOADER_OE = 1'b0;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL ram_write: unexpected request adr/wdat/be=%h, none expected", snap);
          end else begin
            exp_v = exp_q.pop_front();
            if (snap !== exp_v) begin
              n_errors++;
              $display("FAIL ram_write: adr/wdat/be got %h expected %h", snap, exp_v);
            end
          end
        end else begin
          n_checks++;
          if ({ram_adr, ram_wdat, ram_be} !== snap) begin
            n_errors++;
            $display("FAIL ram_stable: got %h expected held %h", {ram_adr, ram_wdat, ram_be}, snap);
          end
        end
        if (dly == 0) begin
          ram_ack = 1'b1;
          @(negedge clk21m);
          ram_ack = 1'b0;
          in_req = 0;
        end else begin
          dly--;
        end
      end
    end
  end

  // driver tasks
  task automatic write_byte(input logic [ADR_W-1:0] adr, input logic [7:0] dat, input int hold);
    bit got;
    got = 0;
    model_write(adr, dat);
    @(negedge clk21m);
    LOADER_ADR  = adr;
    LOADER_WDAT = dat;
    LOADER_WR   = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk21m);
      if (LOADER_ACK) begin
        got = 1;
        break;
      end
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL loader_ack: adr %h got no ACK in 200 cycles, required one pulse", adr);
    end
    repeat (hold) @(negedge clk21m);
    LOADER_WR = 1'b0;
    @(negedge clk21m);
  endtask

  task automatic wait_settle(input bit need_idle);
    int stable;
    stable = 0;
    for (int i = 0; i < 300 && stable < 3; i++) begin
      @(negedge clk21m);
      if (exp_q.size() == 0 && !ram_req && (!need_idle || !busy)) stable++;
      else stable = 0;
    end
    n_checks++;
    if (stable < 3) begin
      n_errors++;
      $display("FAIL settle: outstanding=%0d ram_req=%b busy=%b after 300 cycles, required drained",
               exp_q.size(), ram_req, busy);
    end
  endtask

  task automatic end_session();
    model_end_session();
    @(negedge clk21m);
    LOADER_OE = 1'b0;
    wait_settle(1);
    LOADER_OE = 1'b1;
    @(negedge clk21m);
  endtask

  task automatic check_counts(input string name, input int a0, input int r0,
                              input int exp_acks, input int exp_reqs);
    n_checks++;
    if (ack_cnt - a0 !== exp_acks) begin
      n_errors++;
      $display("FAIL %s_acks: got %0d expected %0d", name, ack_cnt - a0, exp_acks);
    end
    n_checks++;
    if (req_cnt - r0 !== exp_reqs) begin
      n_errors++;
      $display("FAIL %s_reqs: got %0d expected %0d", name, req_cnt - r0, exp_reqs);
    end
  endtask

  // tests
  task automatic test_reset();
    n_checks++;
    if ({LOADER_ACK, ram_req, busy} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_ctrl: ack/req/busy got %b expected 000", {LOADER_ACK, ram_req, busy});
    end
    n_checks++;
    if ({ram_adr, ram_wdat, ram_be} !== '0) begin
      n_errors++;
      $display("FAIL reset_data: adr/wdat/be got %h expected 0", {ram_adr, ram_wdat, ram_be});
    end
    n_checks++;
    if (drop_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_drop: got %0d expected 0", drop_cnt);
    end
  endtask

  task automatic test_pair();
    int a0, r0;
    a0 = ack_cnt; r0 = req_cnt;
    write_byte(19'h00000, 8'h11, 2);
    write_byte(19'h00001, 8'h22, 2);
    wait_settle(1);
    check_counts("pair", a0, r0, 2, 1);
  endtask

  task automatic test_trailing_wr();
    int a0, r0;
    a0 = ack_cnt; r0 = req_cnt;
    write_byte(19'h00003, 8'h33, 3);
    wait_settle(1);
    check_counts("trailing", a0, r0, 1, 1);
    write_byte(19'h00005, 8'h44, 0);
    wait_settle(1);
    check_counts("rearm", a0, r0, 2, 2);
  endtask

  task automatic test_flush_even();
    int a0, r0;
    a0 = ack_cnt; r0 = req_cnt;
    write_byte(19'h00010, 8'hAA, 1);
    write_byte(19'h00012, 8'hBB, 1);
    wait_settle(0);
    check_counts("flush_even", a0, r0, 2, 1);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_even_pending: busy got %b expected 1", busy);
    end
    end_session();
    check_counts("flush_even_end", a0, r0, 2, 2);
  endtask

  task automatic test_odd_nopend();
    int a0, r0;
    a0 = ack_cnt; r0 = req_cnt;
    write_byte(19'h00021, 8'h5C, 1);
    write_byte(19'h00030, 8'h77, 2);
    end_session();
    check_counts("odd_nopend", a0, r0, 2, 2);
  endtask

  task automatic test_drop();
    int a0, r0;
    a0 = ack_cnt; r0 = req_cnt;
    write_byte(19'h00100, 8'hEE, 1);
    wait_settle(1);
    check_counts("drop", a0, r0, 1, 0);
    n_checks++;
    if (drop_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL drop_one: drop_cnt got %0d expected 1", drop_cnt);
    end
    write_byte(19'h00060, 8'h66, 1);
    write_byte(19'h001FF, 8'h01, 0);
    write_byte(19'h00061, 8'h67, 1);
    wait_settle(1);
    n_checks++;
    if (drop_cnt !== 8'(m_drop)) begin
      n_errors++;
      $display("FAIL drop_keep_pend: drop_cnt got %0d expected %0d", drop_cnt, m_drop);
    end
    for (int i = 0; i < 300; i++) write_byte(19'h00100 + 19'($urandom_range(0, 511)), 8'h5A, 0);
    wait_settle(1);
    n_checks++;
    if (drop_cnt !== 8'd255) begin
      n_errors++;
      $display("FAIL drop_sat: drop_cnt got %0d expected 255", drop_cnt);
    end
  endtask

  task automatic test_oe_mid_write();
    int a0, r0;
    a0 = ack_cnt; r0 = req_cnt;
    write_byte(19'h00040, 8'h01, 1);
    oe_drop = 1;
    write_byte(19'h00041, 8'h02, 1);
    oe_drop = 0;
    wait_settle(1);
    LOADER_OE = 1'b1;
    @(negedge clk21m);
    check_counts("oe_mid_write", a0, r0, 2, 1);
  endtask

  task automatic test_random();
    int a0, nw;
    logic [ADR_W-1:0] adr, prev;
    a0 = ack_cnt;
    nw = 0;
    prev = '0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) adr = prev ^ 19'h1;
      else adr = 19'($urandom_range(0, 32'h13F));
      write_byte(adr, 8'($urandom_range(0, 255)), $urandom_range(0, 2));
      nw++;
      prev = adr;
      if ($urandom_range(0, 7) == 0) end_session();
    end
    end_session();
    n_checks++;
    if (ack_cnt - a0 !== nw) begin
      n_errors++;
      $display("FAIL random_acks: got %0d expected %0d", ack_cnt - a0, nw);
    end
    n_checks++;
    if (drop_cnt !== 8'(m_drop)) begin
      n_errors++;
      $display("FAIL random_drop: drop_cnt got %0d expected %0d", drop_cnt, m_drop);
    end
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    int a0, r0;
    seen = 0;
    resp_en = 0;
    @(negedge clk21m);
    LOADER_ADR  = 19'h00051;
    LOADER_WDAT = 8'h99;
    LOADER_WR   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk21m);
      if (ram_req) begin
        seen = 1;
        break;
      end
    end
    LOADER_WR = 1'b0;
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL rst_write_req: ram_req got 0 within 20 cycles, expected 1");
    end
    @(negedge clk21m);
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({ram_req, busy, LOADER_ACK} !== 3'b000) begin
      n_errors++;
      $display("FAIL rst_async: req/busy/ack got %b expected 000", {ram_req, busy, LOADER_ACK});
    end
    @(negedge clk21m);
    rstn = 1'b1;
    m_pend_v = 0;
    m_drop = 0;
    exp_q.delete();
    @(negedge clk21m);
    ram_ack = 1'b1;
    @(negedge clk21m);
    ram_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({ram_req, busy, LOADER_ACK} !== 3'b000) begin
        n_errors++;
        $display("FAIL rst_late_ack: req/busy/ack got %b expected 000", {ram_req, busy, LOADER_ACK});
      end
      @(negedge clk21m);
    end
    resp_en = 1;
    a0 = ack_cnt; r0 = req_cnt;
    write_byte(19'h00070, 8'hA5, 2);
    write_byte(19'h00071, 8'h5A, 2);
    wait_settle(1);
    check_counts("after_reset", a0, r0, 2, 1);
    n_checks++;
    if (drop_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL after_reset_drop: drop_cnt got %0d expected 0", drop_cnt);
    end
  endtask

  initial begin
    rstn        = 1'b0;
    LOADER_OE   = 1'b1;
    LOADER_WR   = 1'b0;
    LOADER_ADR  = '0;
    LOADER_WDAT = '0;
    ram_ack     = 1'b0;
    repeat (3) @(negedge clk21m);
    test_reset();
    rstn = 1'b1;
    @(negedge clk21m);
    test_pair();
    test_trailing_wr();
    test_flush_even();
    test_odd_nopend();
    test_drop();
    test_oe_mid_write();
    test_random();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/loader_sdram_sink.md
Name: loader_sdram_sink

Overview:
- Target end of the ROM/image loader handshake: accepts byte writes (LOADER_WR/ADR/WDAT), returns one LOADER_ACK pulse per byte.
- Packs even/odd byte pairs into 16-bit SDRAM write requests with byte enables; issues them on a req/ack port to the SDRAM arbiter.
- Sits inside the PC88 top, between the loader pins and the SDRAM controller's loader port.

Parameters:
- ADR_W, 19, loader byte-address width.
- RAM_AW, 24, SDRAM word-address width.
- BASE, 0, word offset added to every SDRAM address.
- LIMIT, 2**19, bytes with LOADER_ADR >= LIMIT are acked but not written.

Ports:
- clk21m  in  1  system clock.
- rstn  in  1  asynchronous reset, active-low.
- LOADER_OE  in  1  loader session active.
- LOADER_WR  in  1  write request level; the requester holds it until it sees ACK rise, so it can stay high up to 2 cycles after ACK.
- LOADER_ADR  in  ADR_W  byte address.
- LOADER_WDAT  in  8  byte data.
- LOADER_ACK  out  1  one-cycle accept pulse.
- ram_req  out  1  SDRAM write request, level.
- ram_ack  in  1  one-cycle completion pulse from the arbiter.
- ram_adr  out  RAM_AW  word address = BASE + ADR[ADR_W-1:1], truncated to RAM_AW.
- ram_wdat  out  16  {odd byte, even byte}.
- ram_be  out  2  [1]=upper/odd byte, [0]=lower/even byte.
- busy  out  1  state != IDLE or a pending byte is held.
- drop_cnt  out  8  saturating count of out-of-range bytes.

Behaviour:
- Reset (async, rstn low):
  - State IDLE; armed=1; pend_v=0.
  - LOADER_ACK=0, ram_req=0, ram_adr=0, ram_wdat=0, ram_be=0, drop_cnt=0.
  - Any outstanding request or pending byte is discarded; a late ram_ack after reset is ignored.
- Re-arm rule: when LOADER_WR is sampled low, set armed=1. A byte is accepted only when LOADER_WR & armed & LOADER_OE in IDLE; acceptance clears armed. This prevents double-accept while WR trails ACK.
- Acceptance registers adr and dat into cap_adr/cap_dat.
- States: IDLE, FLUSH, PROC, WRITE.
- IDLE:
  - On accept with cap_adr >= LIMIT: pulse ACK next cycle, drop_cnt+1 (saturates at 255), no RAM access, pending byte kept.
  - On accept with pend_v and (cap_adr[0]==0 or cap_adr[ADR_W-1:1] != pend_adr): go to FLUSH with next=PROC.
  - Other accepts: go to PROC.
  - If LOADER_OE is low and pend_v: go to FLUSH with next=IDLE (end-of-session flush).
- FLUSH:
  - Drives ram_req=1, ram_adr from pend_adr, ram_wdat={8'h00, pend_dat}, ram_be=2'b01.
  - On ram_ack: ram_req=0 in the same cycle's next edge, pend_v=0, go to next.
- PROC (single cycle):
  - Even address: store pend_adr/pend_dat, pend_v=1, pulse ACK, go to IDLE. No RAM access.
  - Odd address with matching pend: go to WRITE with wdat={cap_dat, pend_dat}, be=2'b11, pend_v=0.
  - Odd address without pend: go to WRITE with wdat={cap_dat, 8'h00}, be=2'b10.
- WRITE: ram_req=1 until ram_ack. On ram_ack: drop ram_req, pulse ACK, go to IDLE.
- ram_adr, ram_wdat and ram_be are stable throughout the cycles ram_req is high.
- ram_ack is ignored when ram_req is low.
- At most one RAM request is in flight at any time.
- LOADER_ACK is registered and never high for two consecutive cycles.
- Latency:
  - Even byte: ACK 2 cycles after accept.
  - Pair completion: ACK 1 cycle after ram_ack.
- LOADER_OE falling mid-WRITE: the write completes and ACK still pulses. A pending byte is flushed once back in IDLE.

Test Plan:
- Bytes 0x11@0x00000, 0x22@0x00001, each WR held until 2 cycles after ACK -> exactly one ram_req, ram_adr=BASE+0, ram_wdat=0x2211, be=11. Exactly 2 ACK pulses.
- WR held high 3 cycles after ACK with no low gap -> no second accept and no second ACK until WR goes low and high again.
- Even 0xAA@0x10 then even 0xBB@0x12 -> flush ram_adr=8, wdat=0x00AA, be=01. Then 0xBB is held pending. Only 2 ACKs.
- Odd 0x5C@0x21 with no pending byte -> ram_adr=0x10, wdat=0x5C00, be=10. Even 0x77@0x30, then LOADER_OE low -> flush ram_adr=0x18, be=01.
- LIMIT=0x100: write @0x100 -> ACK pulses, no ram_req, drop_cnt=1. 300 such writes -> drop_cnt=255.
- rstn low while ram_req is high in WRITE -> ram_req=0 and busy=0 immediately. A following ram_ack is ignored. A subsequent write pair completes normally.
